button_repeater: RTL and testbench

Turns the debounced button levels into one-cycle game-action pulses with keyboard-style auto-repeat. It sits between the per-button debouncers and the Tetris game controller. Each press produces one immediate pulse. A channel with repeat enabled that stays held then produces a pulse after an initial delay, followed by a pulse at a fixed repeat rate. A shared free-running tick sets all delay and repeat timing. The default tick is 10 ms at 100 MHz.

---
 rtl/button_repeater.sv | 131 +++++++++++++
 tb/tb_button_repeater.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/button_repeater.sv
// button_repeater: turns debounced button levels into one-cycle action pulses.
// Every press gives one pulse immediately. Channels with repeat enabled then
// pulse again after an initial delay and at a fixed rate while still held.
// All delay and repeat timing comes from one shared free-running tick.
module button_repeater #(
  parameter int             N            = 4,
  parameter int             TICK_CYCLES  = 1_000_000,
  parameter int             DELAY_TICKS  = 20,
  parameter int             REPEAT_TICKS = 5,
  parameter logic [N-1:0]   REPEAT_MASK  = 4'b0111
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn,
  output logic [N-1:0] pulse,
  output logic [N-1:0] held
);

  localparam int TW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int MAXT = (DELAY_TICKS > REPEAT_TICKS) ? DELAY_TICKS : REPEAT_TICKS;
  localparam int CW   = (MAXT > 0) ? $clog2(MAXT + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  // state   | meaning
  // S_IDLE  | button released, waiting for a press
  // S_DELAY | pressed, press pulse issued, counting ticks to first repeat
  // S_REPEAT| auto-repeating, counting ticks between repeat pulses
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  state_t        state_q [N];
  state_t        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  pulse_q, pulse_d;
  logic [N-1:0]  held_q, held_d;

  assign tick  = (tick_cnt_q == TICK_LAST);
  assign pulse = pulse_q;
  assign held  = held_q;

  // Free-running tick counter; presses never restart it.
  always_comb begin
    tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_ONE);
  end

  // Per-channel next state, counter and pulse; release beats tick.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (btn[i]) begin
            state_d[i] = S_DELAY;
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
          end
        end
        S_DELAY: begin
          if (!btn[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (!REPEAT_MASK[i]) begin
            cnt_d[i] = '0;
          end else if (tick) begin
            if (cnt_q[i] == DELAY_LAST) begin
              state_d[i] = S_REPEAT;
              cnt_d[i]   = '0;
              pulse_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        end
        S_REPEAT: begin
          if (!btn[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == REPEAT_LAST) begin
              cnt_d[i]   = '0;
              pulse_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] != S_IDLE);
    end
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      pulse_q    <= '0;
      held_q     <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pulse_q    <= pulse_d;
      held_q     <= held_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_repeater.sv
// Directed bench for button_repeater with TICK_CYCLES=4, DELAY_TICKS=3,
// REPEAT_TICKS=2, REPEAT_MASK=4'b0111. Edge e counts rising edges after
// reset release (edge 0 first); outputs are sampled 1 time unit after edges.
module tb_button_repeater;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] pulse;
  logic [3:0] held;

  int total;
  int bad;

  button_repeater #(
    .N           (4),
    .TICK_CYCLES (4),
    .DELAY_TICKS (3),
    .REPEAT_TICKS(2),
    .REPEAT_MASK (4'b0111)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .pulse(pulse),
    .held (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Holds reset across two edges with btn applied, then releases it just
  // after an edge so that the following edge is edge 0.
  task automatic do_reset(input logic [3:0] b);
    btn   = b;
    reset = 1'b1;
    #2;
    check("rst_pulse_a", pulse, 4'b0000);
    check("rst_held_a", held, 4'b0000);
    step();
    check("rst_pulse_b", pulse, 4'b0000);
    check("rst_held_b", held, 4'b0000);
    step();
    check("rst_pulse_c", pulse, 4'b0000);
    check("rst_held_c", held, 4'b0000);
    reset = 1'b0;
  endtask

  initial begin
    int pc;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    btn   = 4'b0000;

    // Reset with all buttons held, then release.
    do_reset(4'b1111);
    step();
    check("all_press_pulse", pulse, 4'b1111);
    check("all_press_held", held, 4'b1111);
    step();
    check("all_single_pulse", pulse, 4'b0000);
    check("all_still_held", held, 4'b1111);
    btn = 4'b0000;
    step();
    check("all_release_held", held, 4'b0000);
    check("all_release_pulse", pulse, 4'b0000);

    // Long hold on channel 0: pulses after edges 0, 11, 19, 27.
    do_reset(4'b0000);
    btn = 4'b0001;
    for (int e = 0; e <= 28; e++) begin
      step();
      if (e == 0 || e == 11 || e == 19 || e == 27)
        check("hold0_pulse_on", pulse, 4'b0001);
      else
        check("hold0_pulse_off", pulse, 4'b0000);
      check("hold0_held", held, 4'b0001);
    end
    btn = 4'b0000;
    step();
    check("hold0_release", held, 4'b0000);

    // Channel 3 (no repeat) held for 100 cycles.
    do_reset(4'b0000);
    btn = 4'b1000;
    pc  = 0;
    for (int e = 0; e < 100; e++) begin
      step();
      if (pulse[3]) pc++;
      check("hold3_held", held, 4'b1000);
    end
    check_int("hold3_pulse_count", pc, 1);
    btn = 4'b0000;
    step();
    check("hold3_release", held, 4'b0000);
    check("hold3_release_pulse", pulse, 4'b0000);

    // Tap on channel 1: 1,1,0,1,1 then release.
    do_reset(4'b0000);
    btn = 4'b0010;
    step();
    check("tap_p0", pulse, 4'b0010);
    check("tap_h0", held, 4'b0010);
    step();
    check("tap_p1", pulse, 4'b0000);
    check("tap_h1", held, 4'b0010);
    btn = 4'b0000;
    step();
    check("tap_p2", pulse, 4'b0000);
    check("tap_h2", held, 4'b0000);
    btn = 4'b0010;
    step();
    check("tap_p3", pulse, 4'b0010);
    check("tap_h3", held, 4'b0010);
    step();
    check("tap_p4", pulse, 4'b0000);
    check("tap_h4", held, 4'b0010);
    btn = 4'b0000;
    step();
    check("tap_p5", pulse, 4'b0000);
    check("tap_h5", held, 4'b0000);

    // Release on the edge (19) that would otherwise fire a repeat.
    do_reset(4'b0000);
    btn = 4'b0001;
    for (int e = 0; e <= 18; e++) begin
      step();
      if (e == 11) check("rel_first_repeat", pulse, 4'b0001);
    end
    btn = 4'b0000;
    step();
    check("rel_tick_pulse", pulse, 4'b0000);
    check("rel_tick_held", held, 4'b0000);
    step();
    check("rel_after_pulse", pulse, 4'b0000);

    // Asynchronous reset while a repeat pulse is showing.
    do_reset(4'b0000);
    btn = 4'b0001;
    for (int e = 0; e <= 11; e++) step();
    check("mid_repeat_pulse", pulse, 4'b0001);
    check("mid_repeat_held", held, 4'b0001);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pulse", pulse, 4'b0000);
    check("async_rst_held", held, 4'b0000);
    step();
    check("async_rst_edge_held", held, 4'b0000);
    reset = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      step();
      if (e == 0 || e == 11)
        check("post_rst_pulse_on", pulse, 4'b0001);
      else
        check("post_rst_pulse_off", pulse, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
